// File: rtl/seed_core_arbiter_if.sv
// Client and core-side signals of the SEED core arbiter.
// slave: the arbiter. master: the requesters plus the core model.
interface seed_core_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = $clog2(NREQ);

  // requester side
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][127:0] data;
  logic [NREQ-1:0][127:0] key;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        valid;
  logic [127:0]           rsp_data;
  logic                   err;
  logic [GW-1:0]          gnt;
  logic                   busy;

  // core side
  logic [127:0]           core_data;
  logic [127:0]           core_key;
  logic                   core_start;
  logic [127:0]           core_rsp;
  logic                   core_done;

  modport slave (
    input  req, data, key, core_rsp, core_done,
    output ack, valid, rsp_data, err, gnt, busy, core_data, core_key, core_start
  );

  modport master (
    output req, data, key, core_rsp, core_done,
    input  ack, valid, rsp_data, err, gnt, busy, core_data, core_key, core_start
  );
endinterface

// File: rtl/seed_core_arbiter.sv
// Round-robin scheduler sharing one SEED128 core among NREQ requesters.
// A job is granted in IDLE, started in START, and then waits in WAIT for done
// or a timeout. The result is then handed back in DELIVER.
// Every output is a register or a decode of registered state.
module seed_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  seed_core_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0]    state;
  logic [GW-1:0] ptr;     // last served requester, lowest priority next round
  logic [GW-1:0] gnt_q;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;
  logic          found;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic [127:0]  rsp_q;
  logic [127:0]  core_data_q;
  logic [127:0]  core_key_q;

  // Cyclic search for the first active request after ptr.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 1; i <= NREQ; i++) begin
      idx = GW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Job sequencing: grant, start pulse, wait for done or timeout, deliver.
  // A done seen outside WAIT belongs to no live job and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= GW'(NREQ - 1);
      gnt_q       <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      rsp_q       <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            core_data_q <= bus.data[pick];
            core_key_q  <= bus.key[pick];
            gnt_q       <= pick;
            state       <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.core_done) begin
            rsp_q <= bus.core_rsp;
            state <= S_DELIVER;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            ptr   <= gnt_q;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ptr   <= gnt_q;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = (state == S_START)   ? (ONE << gnt_q) : '0;
  assign bus.valid      = (state == S_DELIVER) ? (ONE << gnt_q) : '0;
  assign bus.core_start = (state == S_START);
  assign bus.busy       = (state != S_IDLE);
  assign bus.err        = err_q;
  assign bus.gnt        = gnt_q;
  assign bus.rsp_data   = rsp_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_key   = core_key_q;
endmodule
